// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer: tracks the light gantry, times the driver's
// press after lights-out in tick units, and flags jump starts and timeouts.
module f1_reaction_timer #(
    parameter int W          = 16,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [7:0]   lights,
    input  logic         button,
    output logic [W-1:0] result,
    output logic         valid,
    output logic         jump_start,
    output logic         timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        FULL,
        TIMING,
        DONE
    } state_t;

    localparam logic [W-1:0] TMO_LAST = W'(TIMEOUT_MS - 1);
    localparam logic [W-1:0] TMO_VAL  = W'(TIMEOUT_MS);

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   result_q, result_d;
    logic           valid_q, valid_d;
    logic           jump_q, jump_d;
    logic           timeout_q, timeout_d;
    logic           button_q;

    logic           press;
    logic           lt_off;
    logic           lt_first;
    logic           lt_full;
    logic           tmo_hit;

    assign press    = button & ~button_q;
    assign lt_off   = (lights == 8'h00);
    assign lt_first = (lights == 8'h01);
    assign lt_full  = (lights == 8'hFF);
    assign tmo_hit  = tick && (count_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            jump_q    <= 1'b0;
            timeout_q <= 1'b0;
            button_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            jump_q    <= jump_d;
            timeout_q <= timeout_d;
            button_q  <= button;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lt_first) state_d = ARMED;
            end
            ARMED: begin
                if (press)        state_d = DONE;
                else if (lt_full) state_d = FULL;
                else if (lt_off)  state_d = IDLE;
            end
            FULL: begin
                if (press)       state_d = DONE;
                else if (lt_off) state_d = TIMING;
            end
            TIMING: begin
                if (press || tmo_hit) state_d = DONE;
            end
            DONE: begin
                if (lt_first) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        jump_d    = jump_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE, DONE: begin
                // A new sequence wipes the previous run's result
                if (lt_first) begin
                    result_d  = '0;
                    jump_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ARMED: begin
                if (press) jump_d = 1'b1;
            end
            FULL: begin
                if (press)       jump_d  = 1'b1;
                else if (lt_off) count_d = '0;
            end
            TIMING: begin
                // A press wins over a coincident tick, which goes uncounted
                if (press) begin
                    result_d = count_q;
                    valid_d  = 1'b1;
                end else if (tmo_hit) begin
                    result_d  = TMO_VAL;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                end else if (tick) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    assign result     = result_q;
    assign valid      = valid_q;
    assign jump_start = jump_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer: two instances (timeouts 2000 and 20) share
// stimulus; a reference model feeds per-cycle expectations to a scoreboard.
module tb_f1_reaction_timer;

    localparam int P_IDLE = 0;
    localparam int P_RAMP = 1;
    localparam int P_FULL = 2;
    localparam int P_RUN  = 3;
    localparam int P_HOLD = 4;

    typedef struct {
        int res;
        bit v;
        bit js;
        bit to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  lights = 8'h00;
    logic        button = 1'b0;

    logic [15:0] res_a, res_b;
    logic        v_a, v_b, js_a, js_b, to_a, to_b;

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_err = 0;

    int tmo[2] = '{2000, 20};
    int ph[2];
    int cnt[2];
    int m_res[2];
    bit m_v[2], m_js[2], m_to[2];
    bit bprev;

    f1_reaction_timer #(.W(16), .TIMEOUT_MS(2000)) u_a (
        .clk(clk), .rst(rst), .tick(tick), .lights(lights),
        .button(button), .result(res_a), .valid(v_a),
        .jump_start(js_a), .timeout(to_a)
    );

    f1_reaction_timer #(.W(16), .TIMEOUT_MS(20)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .lights(lights),
        .button(button), .result(res_b), .valid(v_b),
        .jump_start(js_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behaviour of one clock edge, written from the rules of a start sequence
    task automatic model_step();
        bit   press;
        exp_t e;
        press = button && !bprev;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ph[k] = P_IDLE; cnt[k] = 0; m_res[k] = 0;
                m_v[k] = 0; m_js[k] = 0; m_to[k] = 0;
            end else begin
                m_v[k] = 0;
                case (ph[k])
                    P_IDLE, P_HOLD: if (lights == 8'h01) begin
                        ph[k] = P_RAMP; m_res[k] = 0; m_js[k] = 0; m_to[k] = 0;
                    end
                    P_RAMP: if (press) begin
                        ph[k] = P_HOLD; m_js[k] = 1;
                    end else if (lights == 8'hFF) ph[k] = P_FULL;
                    else if (lights == 8'h00) ph[k] = P_IDLE;
                    P_FULL: if (press) begin
                        ph[k] = P_HOLD; m_js[k] = 1;
                    end else if (lights == 8'h00) begin
                        ph[k] = P_RUN; cnt[k] = 0;
                    end
                    P_RUN: if (press) begin
                        ph[k] = P_HOLD; m_res[k] = cnt[k]; m_v[k] = 1;
                    end else if (tick) begin
                        cnt[k]++;
                        if (cnt[k] == tmo[k]) begin
                            ph[k] = P_HOLD; m_res[k] = tmo[k];
                            m_to[k] = 1; m_v[k] = 1;
                        end
                    end
                    default: ph[k] = P_IDLE;
                endcase
            end
        end
        bprev = rst ? 1'b0 : button;
        e.res = m_res[0]; e.v = m_v[0]; e.js = m_js[0]; e.to = m_to[0];
        q0.push_back(e);
        e.res = m_res[1]; e.v = m_v[1]; e.js = m_js[1]; e.to = m_to[1];
        q1.push_back(e);
    endtask

    task automatic drive(input bit r, input bit t, input logic [7:0] l, input bit b);
        @(negedge clk);
        rst = r; tick = t; lights = l; button = b;
        model_step();
    endtask

    task automatic ramp(input bit b);
        logic [7:0] l;
        l = 8'h01;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, l, b);
            drive(0, 0, l, b);
            l = {l[6:0], 1'b1};
        end
    endtask

    task automatic ticks(input int n, input bit b);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 8'h00, b);
            repeat ($urandom_range(0, 2)) drive(0, 0, 8'h00, b);
        end
    endtask

    task automatic idle(input int n, input logic [7:0] l);
        repeat (n) drive(0, 0, l, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("a.result", int'(res_a), e.res);
                check("a.valid", int'(v_a), int'(e.v));
                check("a.jump_start", int'(js_a), int'(e.js));
                check("a.timeout", int'(to_a), int'(e.to));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("b.result", int'(res_b), e.res);
                check("b.valid", int'(v_b), int'(e.v));
                check("b.jump_start", int'(js_b), int'(e.js));
                check("b.timeout", int'(to_b), int'(e.to));
            end
        end
    end

    initial begin : stim
        logic [7:0] l;
        drive(1, 0, 8'h00, 0);
        drive(1, 1, 8'h01, 1);
        idle(2, 8'h00);

        // normal run; the tick in the lights-out cycle must not count
        ramp(0);
        drive(0, 1, 8'h00, 0);
        ticks(250, 0);
        drive(0, 0, 8'h00, 1);
        idle(3, 8'h00);

        // jump start during ramp, then a press in full is ignored
        drive(0, 0, 8'h01, 0);
        drive(0, 0, 8'h03, 0);
        drive(0, 0, 8'h07, 0);
        drive(0, 0, 8'h0F, 1);
        drive(0, 0, 8'h0F, 0);
        drive(0, 0, 8'hFF, 1);
        drive(0, 0, 8'hFF, 0);
        idle(3, 8'h00);

        // 25 ticks: the 20 ms instance times out, then a late press
        ramp(0);
        drive(0, 0, 8'h00, 0);
        ticks(25, 0);
        idle(3, 8'h00);
        drive(0, 0, 8'h00, 1);
        idle(3, 8'h00);

        // full-length timeout on the 2000 ms instance
        ramp(0);
        drive(0, 0, 8'h00, 0);
        repeat (2000) drive(0, 1, 8'h00, 0);
        idle(2, 8'h00);
        drive(0, 1, 8'h00, 1);
        idle(2, 8'h00);

        // tick and press together at count 7
        ramp(0);
        drive(0, 0, 8'h00, 0);
        ticks(7, 0);
        drive(0, 1, 8'h00, 1);
        idle(3, 8'h00);

        // press in the lights-out cycle
        ramp(0);
        drive(0, 0, 8'h00, 1);
        idle(3, 8'h00);

        // button held through the sequence, then release and press
        repeat (3) drive(0, 0, 8'h00, 1);
        ramp(1);
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0);
        ticks(5, 0);
        drive(0, 0, 8'h00, 1);
        idle(2, 8'h00);
        drive(0, 0, 8'h01, 0);
        drive(0, 0, 8'h00, 0);
        idle(2, 8'h00);

        // reset at count 100, then a press that must do nothing
        ramp(0);
        drive(0, 0, 8'h00, 0);
        ticks(100, 0);
        drive(1, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 1);
        idle(3, 8'h00);

        // randomized sequences with glitches, aborts, stray presses and resets
        for (int it = 0; it < 25; it++) begin
            l = 8'h01;
            for (int s = 0; s < 8; s++) begin
                if ($urandom_range(0, 29) == 0) break;
                repeat ($urandom_range(1, 3))
                    drive(0, $urandom_range(0, 1),
                          ($urandom_range(0, 9) == 0) ? 8'h5A : l,
                          $urandom_range(0, 15) == 0);
                l = {l[6:0], 1'b1};
            end
            repeat ($urandom_range(5, 120))
                drive($urandom_range(0, 299) == 0, $urandom_range(0, 1),
                      8'h00, $urandom_range(0, 40) == 0);
            idle(5, 8'h00);
        end

        idle(3, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
